// File: rtl/ex_mem_lsu.sv
// MEM-stage load/store unit: word-wide data-cache handshake, read-modify-write sub-word stores,
// sign/zero-extended loads. Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them.
module ex_mem_lsu #(
  parameter int XLEN       = 32,
  parameter int MEM_ADDR_W = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  lsu_stall,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       load_data,
  output logic                  misalign,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_stall
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_RMW_RD, S_RMW_WR, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            is_byte, is_half, sub_store, mis_d, accept;
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ext_data, merged;

  // Access decode; funct3[1:0]=1x (incl. the undefined encodings) behaves as a word.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    is_byte   = (req_funct3[1:0] == 2'b00);
    is_half   = (req_funct3[1:0] == 2'b01);
    off       = is_byte ? req_addr[1:0] : (is_half ? {req_addr[1], 1'b0} : 2'b00);
    sub_store = req_we && (is_byte || is_half);
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d     = (is_half && req_addr[0]) ||
                (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
`else
    mis_d     = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_rdata[{off, 3'b000} +: 8];
    half_sel = mem_rdata[{off[1], 4'b0000} +: 16];
    if (is_byte)
      ext_data = req_funct3[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                               : {{(XLEN-8){byte_sel[7]}}, byte_sel};
    else if (is_half)
      ext_data = req_funct3[2] ? {{(XLEN-16){1'b0}}, half_sel}
                               : {{(XLEN-16){half_sel[15]}}, half_sel};
    else
      ext_data = mem_rdata;

    merged = mem_rdata;
    if (is_byte)
      merged[{off, 3'b000} +: 8] = req_wdata[7:0];
    else if (is_half)
      merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = mis_d ? S_RESP : (sub_store ? S_RMW_RD : S_ACC);
      S_ACC:    if (!mem_stall) state_d = S_RESP;
      S_RMW_RD: if (!mem_stall) state_d = S_RMW_WR;
      S_RMW_WR: if (!mem_stall) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stall is masked during reset so the pipeline sees a quiet LSU while rst_n is low.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_ACC: begin
        mem_read  = !req_we;
        mem_write = req_we;
      end
      S_RMW_RD: mem_read   = 1'b1;
      S_RMW_WR: mem_write  = 1'b1;
      S_RESP:   resp_valid = 1'b1;
      default: ;
    endcase
    lsu_stall = rst_n && req_valid && (state_q != S_RESP);
  end

  assign accept = (state_q == S_IDLE) && req_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      misalign  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mem_addr  <= req_addr[XLEN-1:2];
        mem_wdata <= (req_we && !sub_store) ? req_wdata : '0;
        load_data <= '0;
        misalign  <= mis_d;
      end
      if ((state_q == S_ACC) && !mem_stall && !req_we)
        load_data <= ext_data;
      if ((state_q == S_RMW_RD) && !mem_stall)
        mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Scoreboard bench for ex_mem_lsu: directed cases plus random traffic against a byte-level
// memory model, with a cache model that inserts a chosen number of stall cycles per request.
module tb_ex_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        lsu_stall, resp_valid, misalign, mem_read, mem_write;
  logic [31:0] load_data, mem_wdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_stall = 1'b0;

  ex_mem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .lsu_stall(lsu_stall), .resp_valid(resp_valid), .load_data(load_data), .misalign(misalign),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] load;
    bit        mis;
    int        lat;
    int        issue_cyc;
    int        nacc;
    bit [1:0]  acc_wr;     // bit i set: cache access i is a write
    bit [29:0] acc_addr;
    bit [31:0] wr_data;
  } exp_t;

  typedef struct {
    bit        wr;
    bit [29:0] addr;
    bit [31:0] data;
  } obs_t;

  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        cur_k = 0;
  bit        hold_writes = 1'b0;
  bit        rw_both = 1'b0;
  int        stall_cnt = 0;
  bit [31:0] cache_mem [bit [29:0]];
  bit [31:0] ref_mem   [bit [29:0]];
  exp_t      sb_q [$];
  obs_t      obs_q [$];
  exp_t      mon_e;
  obs_t      obs_tmp;
  bit        got;
  bit        r_we;
  bit [2:0]  r_f3;
  bit [31:0] r_addr, r_wd;
  int        r_k;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic preload(input bit [29:0] w, input bit [31:0] d);
    cache_mem[w] = d;
    ref_mem[w]   = d;
  endtask

  // Reference behaviour: byte-lane arithmetic on a word memory, plus expected cache traffic.
  function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                 input bit [31:0] wd, input int k);
    exp_t        e;
    int unsigned nb;
    int unsigned lane;
    bit [31:0]   a, word, mask, val;
    e = '{default: 0};
    case (f3)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      default:        nb = 4;
    endcase
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % nb) != 0) begin
      e.mis = 1'b1;
      e.lat = 2;
      return e;
    end
`endif
    a          = addr - (addr % nb);
    lane       = a % 4;
    e.acc_addr = a[31:2];
    word       = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    if (!we) begin
      val = (word >> (8 * lane)) & mask;
      if (nb < 4 && !f3[2] && val[8*nb-1]) val = val | ~mask;
      e.load   = val;
      e.lat    = 3 + k;
      e.nacc   = 1;
      e.acc_wr = 2'b00;
    end else begin
      word = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      ref_mem[a[31:2]] = word;
      e.wr_data = word;
      if (nb == 4) begin
        e.nacc = 1; e.acc_wr = 2'b01; e.lat = 3 + k;
      end else begin
        e.nacc = 2; e.acc_wr = 2'b10; e.lat = 4 + 2 * k;
      end
    end
    return e;
  endfunction

  // Cache model: each request stalls cur_k cycles, then completes.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt = 0;
      mem_stall = 1'b0;
    end else begin
      mem_rdata = cache_mem.exists(mem_addr) ? cache_mem[mem_addr] : 32'h0;
      if (mem_read || mem_write) begin
        if (mem_read && mem_write) rw_both = 1'b1;
        if ((mem_write && hold_writes) || stall_cnt < cur_k) begin
          mem_stall = 1'b1;
          stall_cnt++;
        end else begin
          mem_stall    = 1'b0;
          stall_cnt    = 0;
          obs_tmp.wr   = mem_write;
          obs_tmp.addr = mem_addr;
          obs_tmp.data = mem_write ? mem_wdata : mem_rdata;
          obs_q.push_back(obs_tmp);
          if (mem_write) cache_mem[mem_addr] = mem_wdata;
        end
      end else begin
        mem_stall = 1'b0;
      end
    end
  end

  // Monitor: compares every response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("load_data", load_data, mon_e.load);
        check("misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
        check("latency", cyc - mon_e.issue_cyc + 1, mon_e.lat);
        check("resp_stall", {31'b0, lsu_stall}, 32'h0);
        check("access_count", obs_q.size(), mon_e.nacc);
        for (int i = 0; i < obs_q.size() && i < mon_e.nacc; i++) begin
          check("acc_kind", {31'b0, obs_q[i].wr}, {31'b0, mon_e.acc_wr[i]});
          check("acc_addr", {2'b0, obs_q[i].addr}, {2'b0, mon_e.acc_addr});
          if (obs_q[i].wr) check("wr_data", obs_q[i].data, mon_e.wr_data);
        end
      end
      check("rw_exclusive", {31'b0, rw_both}, 32'h0);
      rw_both = 1'b0;
      obs_q.delete();
    end
  end

  // Drives one request at posedge+1 and returns at posedge+1 after its response.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input int k);
    exp_t e;
    bit   seen;
    e = model(we, f3, addr, wd, k);
    e.issue_cyc = cyc;
    cur_k = k;
    sb_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    check("stall_on_issue", {31'b0, lsu_stall}, 32'h1);
    seen = resp_valid;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 100 cycles");
      finish_run();
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_stall", {31'b0, lsu_stall}, 32'h0);
    check("rst_resp", {31'b0, resp_valid}, 32'h0);
    check("rst_rw", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_addr", {2'b0, mem_addr}, 32'h0);
    check("rst_load", load_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word load, byte/half loads with both extensions.
    preload(30'h40, 32'h8899AABB);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0);
    preload(30'h40, 32'h80112233);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 0);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 0);
    issue(1'b0, 3'b101, 32'h100, 32'h0, 1);

    // Byte store through read-modify-write with two stall cycles per request.
    preload(30'h40, 32'h11223344);
    issue(1'b1, 3'b000, 32'h101, 32'h000000EE, 2);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0);

    // Back-to-back store then load of the same word.
    issue(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 0);
    issue(1'b0, 3'b010, 32'h104, 32'h0, 0);

    // Misaligned word load (trapped or issued as an aligned read depending on build).
    issue(1'b0, 3'b010, 32'h102, 32'h0, 0);

    // Reset while RMW write is held off by the cache.
    preload(30'h40, 32'h11223344);
    cur_k = 0;
    hold_writes = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101; req_wdata = 32'hEE;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_write;
    end
    check("rmw_wr_reached", {31'b0, got}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rw", {30'b0, mem_read, mem_write}, 32'h0);
    check("mid_rst_stall", {31'b0, lsu_stall}, 32'h0);
    check("mid_rst_resp", {30'b0, resp_valid, misalign}, 32'h0);
    check("mid_rst_addr", {2'b0, mem_addr}, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0;
    hold_writes = 1'b0;
    obs_q.delete();
    rw_both = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0);

    // Random traffic over eight words with random stalls and idle gaps.
    for (int w = 0; w < 8; w++) preload(30'h40 + 30'(w), $urandom);
    for (int n = 0; n < 150; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'h100 + 32'($urandom_range(0, 31));
      r_wd   = $urandom;
      r_k    = $urandom_range(0, 3);
      issue(r_we, r_f3, r_addr, r_wd, r_k);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'h0);
    finish_run();
  end

endmodule
